// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions: widths, pad constants and padder state encoding.
package sha256_pkg;

   localparam int unsigned SHA256_WORD_W      = 32;
   localparam int unsigned SHA256_BLOCK_W     = 512;
   localparam int unsigned SHA256_BLOCK_WORDS = SHA256_BLOCK_W / SHA256_WORD_W;

   localparam logic [7:0]               SHA256_PAD_BYTE = 8'h80;
   localparam logic [SHA256_WORD_W-1:0] SHA256_PAD_WORD = {SHA256_PAD_BYTE, 24'h000000};

   typedef logic [SHA256_WORD_W-1:0] sha256_word_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      HOLD  = 2'd1,
      EXTRA = 2'd2
   } padder_state_e;

endpackage

// File: rtl/sha256_pad_word.sv
// Inserts the 0x80 pad byte after the first nbytes (1..4) bytes of a big-endian word and zeroes the tail.
module sha256_pad_word
   import sha256_pkg::*;
(
   input  sha256_word_t word,
   input  logic [2:0]   nbytes,
   output sha256_word_t padded_c
);

   always_comb begin
      padded_c = word;
      case (nbytes)
         3'd1:    padded_c = {word[31:24], SHA256_PAD_BYTE, 16'h0000};
         3'd2:    padded_c = {word[31:16], SHA256_PAD_BYTE, 8'h00};
         3'd3:    padded_c = {word[31:8], SHA256_PAD_BYTE};
         default: padded_c = word;
      endcase
   end

endmodule

// File: rtl/sha256_message_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks with FIPS 180-4 padding.
// Define SHA256_PADDER_BYTE_EN to honour last_bytes_i; otherwise every last word is 4 bytes.
module sha256_message_padder
   import sha256_pkg::*;
#(
   parameter int unsigned LEN_W = 64
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [SHA256_WORD_W-1:0]  data_i,
   input  logic                      v_i,
   input  logic                      last_i,
   input  logic [1:0]                last_bytes_i,
   output logic                      ready_o,
   output logic [SHA256_BLOCK_W-1:0] M_o,
   output logic                      block_v_o,
   input  logic                      block_yumi_i,
   output logic                      first_o,
   output logic                      last_o
);

   // Packed index 15 holds word 0, so word 0 lands in M_o[511:480].
   typedef logic [SHA256_BLOCK_WORDS-1:0][SHA256_WORD_W-1:0] block_t;

   padder_state_e    state_q, state_d;
   logic [3:0]       ctr_q, ctr_d;
   logic [LEN_W-1:0] len_q, len_d;
   block_t           blk_q, blk_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             extra_q, extra_d;
   logic             pad80_q, pad80_d;

   logic [2:0]       nbytes_c;
   sha256_word_t     padded_c;
   logic [63:0]      len64_c;
   logic [4:0]       pad_idx_c;
   logic             accept_c;

`ifdef SHA256_PADDER_BYTE_EN
   assign nbytes_c = (last_bytes_i == 2'd0) ? 3'd4 : {1'b0, last_bytes_i};
`else
   logic unused_last_bytes;
   assign unused_last_bytes = ^last_bytes_i;
   assign nbytes_c          = 3'd4;
`endif

   sha256_pad_word u_pad_word (
      .word     (data_i),
      .nbytes   (nbytes_c),
      .padded_c (padded_c)
   );

   assign accept_c = v_i & ready_o;
   assign M_o      = blk_q;

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      len_d     = len_q;
      blk_d     = blk_q;
      first_d   = first_q;
      last_d    = last_q;
      extra_d   = extra_q;
      pad80_d   = pad80_q;
      len64_c   = '0;
      pad_idx_c = '0;

      unique case (state_q)
         FILL: begin
            if (accept_c) begin
               ctr_d = ctr_q + 4'd1;
               if (!last_i) begin
                  len_d = len_q + LEN_W'(SHA256_WORD_W);
                  blk_d[4'd15 - ctr_q] = data_i;
                  if (ctr_q == 4'd15) begin
                     state_d = HOLD;
                     last_d  = 1'b0;
                  end
               end else begin
                  len_d     = len_q + LEN_W'({nbytes_c, 3'b000});
                  len64_c   = 64'(len_d);
                  // A full last word pushes the pad byte into the following word (16 = next block).
                  pad_idx_c = (nbytes_c == 3'd4) ? ({1'b0, ctr_q} + 5'd1) : {1'b0, ctr_q};
                  for (int unsigned j = 0; j < SHA256_BLOCK_WORDS; j++) begin
                     if (5'(j) == {1'b0, ctr_q}) begin
                        blk_d[4'(15 - j)] = padded_c;
                     end else if (5'(j) > {1'b0, ctr_q}) begin
                        blk_d[4'(15 - j)] = (5'(j) == pad_idx_c) ? SHA256_PAD_WORD : '0;
                     end
                  end
                  if (pad_idx_c <= 5'd13) begin
                     blk_d[4'd1] = len64_c[63:32];
                     blk_d[4'd0] = len64_c[31:0];
                     last_d      = 1'b1;
                     extra_d     = 1'b0;
                  end else begin
                     last_d      = 1'b0;
                     extra_d     = 1'b1;
                     pad80_d     = (pad_idx_c == 5'd16);
                  end
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (block_yumi_i) begin
               first_d = 1'b0;
               if (extra_q) begin
                  state_d = EXTRA;
               end else begin
                  state_d = FILL;
                  ctr_d   = '0;
                  if (last_q) begin
                     first_d = 1'b1;
                     len_d   = '0;
                  end
               end
            end
         end
         EXTRA: begin
            len64_c = 64'(len_q);
            blk_d   = '0;
            if (pad80_q) begin
               blk_d[4'd15] = SHA256_PAD_WORD;
            end
            blk_d[4'd1] = len64_c[63:32];
            blk_d[4'd0] = len64_c[31:0];
            last_d      = 1'b1;
            extra_d     = 1'b0;
            pad80_d     = 1'b0;
            state_d     = HOLD;
         end
         default: state_d = FILL;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= FILL;
         ctr_q     <= '0;
         len_q     <= '0;
         blk_q     <= '0;
         first_q   <= 1'b1;
         last_q    <= 1'b0;
         extra_q   <= 1'b0;
         pad80_q   <= 1'b0;
         ready_o   <= 1'b1;
         block_v_o <= 1'b0;
         first_o   <= 1'b0;
         last_o    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctr_q     <= ctr_d;
         len_q     <= len_d;
         blk_q     <= blk_d;
         first_q   <= first_d;
         last_q    <= last_d;
         extra_q   <= extra_d;
         pad80_q   <= pad80_d;
         ready_o   <= (state_d == FILL);
         block_v_o <= (state_d == HOLD);
         first_o   <= (state_d == HOLD) & first_d;
         last_o    <= (state_d == HOLD) & last_d;
      end
   end

endmodule

// File: tb/tb_sha256_message_padder.sv
// Self-checking bench: known-answer table, reset corner cases, and random messages vs a byte-level FIPS padding model.
`timescale 1ns/1ps
module tb_sha256_message_padder;

   logic         clk_i;
   logic         reset_n_i;
   logic [31:0]  data_i;
   logic         v_i;
   logic         last_i;
   logic [1:0]   last_bytes_i;
   logic         ready_o;
   logic [511:0] M_o;
   logic         block_v_o;
   logic         block_yumi_i;
   logic         first_o;
   logic         last_o;

   sha256_message_padder dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .data_i       (data_i),
      .v_i          (v_i),
      .last_i       (last_i),
      .last_bytes_i (last_bytes_i),
      .ready_o      (ready_o),
      .M_o          (M_o),
      .block_v_o    (block_v_o),
      .block_yumi_i (block_yumi_i),
      .first_o      (first_o),
      .last_o       (last_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [511:0] m;
      logic         first;
      logic         last;
   } blk_t;

   typedef struct {
      logic [31:0]  data;
      logic [1:0]   lb;
      logic [511:0] m;
   } vec_t;

   int           checks   = 0;
   int           failures = 0;
   logic [31:0]  words_q[$];
   logic [1:0]   lb_g;
   blk_t         exp_q[$];
   vec_t         vecs[4];

   function automatic logic [511:0] mk(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w15);
      return {w0, w1, 416'h0, w15};
   endfunction

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: pad the effective message bytes per FIPS 180-4 and slice into 64-byte blocks.
   task automatic build_exp();
      logic [7:0]   p[$];
      logic [31:0]  w;
      logic [63:0]  bits;
      logic [511:0] m;
      int           len;
      int           nb;
      exp_q.delete();
`ifdef SHA256_PADDER_BYTE_EN
      len = 4 * (words_q.size() - 1) + ((lb_g == 2'd0) ? 4 : int'(lb_g));
`else
      len = 4 * words_q.size();
`endif
      for (int i = 0; i < len; i++) begin
         w = words_q[i / 4];
         p.push_back(w[31 - 8 * (i % 4) -: 8]);
      end
      bits = 64'(len) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bits[8 * i +: 8]);
      nb = p.size() / 64;
      for (int b = 0; b < nb; b++) begin
         m = '0;
         for (int i = 0; i < 64; i++) m[511 - 8 * i -: 8] = p[64 * b + i];
         exp_q.push_back('{m: m, first: (b == 0), last: (b == nb - 1)});
      end
   endtask

   task automatic load_rand(input int n, input int lb);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      lb_g = 2'(lb);
      build_exp();
   endtask

   // Streams words_q, holds each block for `stall` extra cycles, and compares against exp_q.
   task automatic run_msg(input string tag, input int stall);
      int   wi;
      int   bi;
      int   hold;
      int   cyc;
      blk_t e;
      wi = 0; bi = 0; hold = 0; cyc = 0;
      while ((wi < words_q.size() || bi < exp_q.size()) && cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
         block_yumi_i = 1'b0;
         v_i          = 1'b0;
         last_i       = 1'b0;
         if (block_v_o) begin
            check1({tag, " ready_in_hold"}, 32'(ready_o), 32'd0);
            checks++;
            if (bi < exp_q.size()) begin
               e = exp_q[bi];
               if ({M_o, first_o, last_o} !== e) begin
                  failures++;
                  $display("FAIL %s blk%0d: M_o=%h f=%b l=%b, expected %h f=%b l=%b",
                           tag, bi, M_o, first_o, last_o, e.m, e.first, e.last);
               end
               if (hold >= stall) begin
                  block_yumi_i = 1'b1;
                  bi++;
                  hold = 0;
               end else begin
                  hold++;
               end
            end else begin
               failures++;
               $display("FAIL %s: unexpected block, got %h, expected none", tag, M_o);
               block_yumi_i = 1'b1;
            end
         end
         // v_i stays high while not ready to show that blocked words are ignored.
         if (wi < words_q.size()) begin
            v_i          = 1'b1;
            data_i       = words_q[wi];
            last_i       = (wi == words_q.size() - 1);
            last_bytes_i = lb_g;
            if (ready_o) wi++;
         end
      end
      if (wi < words_q.size() || bi < exp_q.size()) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: words %0d of %0d, blocks %0d of %0d", tag, wi, words_q.size(), bi, exp_q.size());
      end
      @(negedge clk_i);
      block_yumi_i = 1'b0;
      v_i          = 1'b0;
      last_i       = 1'b0;
   endtask

   task automatic feed(input int n);
      int k;
      int cyc;
      k = 0; cyc = 0;
      while (k < n && cyc < 200) begin
         @(negedge clk_i);
         cyc++;
         v_i    = 1'b1;
         last_i = 1'b0;
         data_i = $urandom;
         if (ready_o) k++;
      end
      if (k < n) begin
         checks++;
         failures++;
         $display("FAIL feed timeout: accepted %0d, expected %0d", k, n);
      end
      @(negedge clk_i);
      v_i = 1'b0;
   endtask

   task automatic pulse_reset(input string tag);
      reset_n_i = 1'b0;
      #1;
      check1({tag, " block_v"}, 32'(block_v_o), 32'd0);
      check1({tag, " ready"}, 32'(ready_o), 32'd1);
      check1({tag, " first"}, 32'(first_o), 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   int dn[8] = '{14, 16, 15, 14, 15, 13, 32, 17};
   int dl[8] = '{0, 0, 0, 3, 1, 0, 0, 2};
   int ds[8] = '{5, 0, 1, 0, 2, 0, 0, 1};

   initial begin
`ifdef SHA256_PADDER_BYTE_EN
      vecs[0] = '{32'h61626300, 2'd3, mk(32'h61626380, 32'h0, 32'h18)};
      vecs[1] = '{32'h61626364, 2'd1, mk(32'h61800000, 32'h0, 32'h08)};
      vecs[2] = '{32'hDEADBEEF, 2'd2, mk(32'hDEAD8000, 32'h0, 32'h10)};
`else
      vecs[0] = '{32'h61626300, 2'd3, mk(32'h61626300, 32'h80000000, 32'h20)};
      vecs[1] = '{32'h61626364, 2'd1, mk(32'h61626364, 32'h80000000, 32'h20)};
      vecs[2] = '{32'hDEADBEEF, 2'd2, mk(32'hDEADBEEF, 32'h80000000, 32'h20)};
`endif
      vecs[3] = '{32'h12345678, 2'd0, mk(32'h12345678, 32'h80000000, 32'h20)};

      reset_n_i    = 1'b0;
      data_i       = '0;
      v_i          = 1'b0;
      last_i       = 1'b0;
      last_bytes_i = '0;
      block_yumi_i = 1'b0;
      #12;
      check1("reset ready", 32'(ready_o), 32'd1);
      check1("reset block_v", 32'(block_v_o), 32'd0);
      check1("reset M_o", 32'(|M_o), 32'd0);
      check1("reset first", 32'(first_o), 32'd0);
      check1("reset last", 32'(last_o), 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      foreach (vecs[i]) begin
         words_q.delete();
         words_q.push_back(vecs[i].data);
         lb_g = vecs[i].lb;
         exp_q.delete();
         exp_q.push_back('{m: vecs[i].m, first: 1'b1, last: 1'b1});
         run_msg($sformatf("vec%0d", i), i);
      end

      for (int i = 0; i < 8; i++) begin
         load_rand(dn[i], dl[i]);
         run_msg($sformatf("dir%0d", i), ds[i]);
      end

      // Reset while a full block is held, then while a message is half fed.
      feed(16);
      check1("hold before reset", 32'(block_v_o), 32'd1);
      pulse_reset("reset_in_hold");
      feed(7);
      pulse_reset("reset_mid_msg");
      words_q.delete();
      words_q.push_back(vecs[0].data);
      lb_g = vecs[0].lb;
      exp_q.delete();
      exp_q.push_back('{m: vecs[0].m, first: 1'b1, last: 1'b1});
      run_msg("after_reset", 0);

      for (int i = 0; i < 25; i++) begin
         load_rand(int'($urandom_range(1, 40)), int'($urandom_range(0, 3)));
         run_msg($sformatf("rnd%0d", i), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
